// File: rtl/rf_pkg.sv
// Shared types for the register-file writeback arbiter and its scoreboard.
package rf_pkg;

    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam int REG_ADR_W = 5;

    typedef logic [REG_ADR_W-1:0] reg_adr_t;

    typedef struct packed {
        logic            valid;
        reg_adr_t        adr;
        logic [XLEN-1:0] data;
    } wb_req_t;

    typedef enum logic {
        MEM_PRI = 1'b0,
        ALU_PRI = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Single-bit pending-write mask with combinational RAW hazard lookups.
module rf_scoreboard #(
    parameter int NREG = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_vld,
    input  rf_pkg::reg_adr_t set_adr,
    input  logic             clr_vld,
    input  rf_pkg::reg_adr_t clr_adr,
    input  rf_pkg::reg_adr_t chk_adr1,
    input  rf_pkg::reg_adr_t chk_adr2,
    input  rf_pkg::reg_adr_t issue_adr,
    output logic             hz1,
    output logic             hz2,
    output logic             hz_rd
);
    import rf_pkg::*;

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;

    // Set is applied after clear so a same-edge issue to a retiring register stays pending.
    always_comb begin
        pending_nxt = pending;
        if (clr_vld && clr_adr != '0)
            pending_nxt[clr_adr] = 1'b0;
        if (set_vld && set_adr != '0)
            pending_nxt[set_adr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pending <= '0;
        else
            pending <= pending_nxt;
    end

    assign hz1   = (chk_adr1  != '0) && pending[chk_adr1];
    assign hz2   = (chk_adr2  != '0) && pending[chk_adr2];
    assign hz_rd = (issue_adr != '0) && pending[issue_adr];

    a_single_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        !(set_vld && set_adr != '0 && pending[set_adr] &&
          !(clr_vld && clr_adr == set_adr)));

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-requester writeback arbiter for the register-file write port, with
// anti-starvation for the ALU path and an integrated RAW scoreboard.
module rf_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int NREG         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  rf_pkg::reg_adr_t mem_adr,
    input  logic [XLEN-1:0]  mem_data,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  rf_pkg::reg_adr_t alu_adr,
    input  logic [XLEN-1:0]  alu_data,
    input  logic             issue_valid,
    input  rf_pkg::reg_adr_t issue_adr,
    input  rf_pkg::reg_adr_t chk_adr1,
    input  rf_pkg::reg_adr_t chk_adr2,
    output logic             hz1,
    output logic             hz2,
    output logic             hz_rd,
    output logic             rf_en,
    output rf_pkg::reg_adr_t rf_w_adr,
    output logic [XLEN-1:0]  rf_w_data
);
    import rf_pkg::*;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    arb_state_t state, state_nxt;
    logic [3:0] starve_cnt, starve_nxt;
    logic       mem_xfer, alu_xfer;
    wb_req_t    win;

    logic             rf_en_p1;
    reg_adr_t         rf_w_adr_p1;
    logic [XLEN-1:0]  rf_w_data_p1;

    always_comb begin
        mem_ready = 1'b0;
        alu_ready = 1'b0;
        if (state == MEM_PRI) begin
            mem_ready = mem_valid;
            alu_ready = alu_valid & ~mem_valid;
        end else begin
            alu_ready = alu_valid;
            mem_ready = mem_valid & ~alu_valid;
        end
    end

    assign mem_xfer = mem_valid & mem_ready;
    assign alu_xfer = alu_valid & alu_ready;

    always_comb begin
        win = '0;
        if (mem_xfer)
            win = '{valid: 1'b1, adr: mem_adr, data: mem_data};
        else if (alu_xfer)
            win = '{valid: 1'b1, adr: alu_adr, data: alu_data};
    end

    // Priority flips on the same edge the counter saturates, so the ALU wins the very next cycle.
    always_comb begin
        starve_nxt = starve_cnt;
        state_nxt  = state;
        if (alu_xfer)
            starve_nxt = '0;
        else if (alu_valid && starve_cnt != STARVE_MAX)
            starve_nxt = starve_cnt + 4'd1;
        case (state)
            MEM_PRI: if (starve_nxt == STARVE_MAX) state_nxt = ALU_PRI;
            ALU_PRI: if (alu_xfer || !alu_valid)   state_nxt = MEM_PRI;
            default: state_nxt = MEM_PRI;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= MEM_PRI;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Output stage: one registered write per accepted transfer; x0 loads but never enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_en_p1     <= 1'b0;
            rf_w_adr_p1  <= '0;
            rf_w_data_p1 <= '0;
        end else if (win.valid) begin
            rf_en_p1     <= (win.adr != '0);
            rf_w_adr_p1  <= win.adr;
            rf_w_data_p1 <= win.data;
        end else begin
            rf_en_p1     <= 1'b0;
        end
    end

    assign rf_en     = rf_en_p1;
    assign rf_w_adr  = rf_w_adr_p1;
    assign rf_w_data = rf_w_data_p1;

    rf_scoreboard #(.NREG(NREG)) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_vld   (issue_valid),
        .set_adr   (issue_adr),
        .clr_vld   (win.valid),
        .clr_adr   (win.adr),
        .chk_adr1  (chk_adr1),
        .chk_adr2  (chk_adr2),
        .issue_adr (issue_adr),
        .hz1       (hz1),
        .hz2       (hz2),
        .hz_rd     (hz_rd)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed-vector bench for rf_wb_arbiter: handshake, output stage, starvation and scoreboard.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_adr;
    logic [31:0] mem_data;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_adr;
    logic [31:0] alu_data;
    logic        issue_valid;
    logic [4:0]  issue_adr, chk_adr1, chk_adr2;
    logic        hz1, hz2, hz_rd;
    logic        rf_en;
    logic [4:0]  rf_w_adr;
    logic [31:0] rf_w_data;

    int vec_cnt = 0;
    int miscmp  = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.XLEN(32), .NREG(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_adr(mem_adr), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_adr(alu_adr), .alu_data(alu_data),
        .issue_valid(issue_valid), .issue_adr(issue_adr),
        .chk_adr1(chk_adr1), .chk_adr2(chk_adr2),
        .hz1(hz1), .hz2(hz2), .hz_rd(hz_rd),
        .rf_en(rf_en), .rf_w_adr(rf_w_adr), .rf_w_data(rf_w_data)
    );

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscmp++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected winners under continuous contention with STARVE_LIMIT=4: 1=mem, 0=alu.
    logic exp_mem [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        rst_n = 1'b0;
        mem_valid = 0; mem_adr = 0; mem_data = 0;
        alu_valid = 0; alu_adr = 0; alu_data = 0;
        issue_valid = 0; issue_adr = 0; chk_adr1 = 0; chk_adr2 = 0;
        tick();
        check_vec("rst_rf_en", {31'd0, rf_en}, 32'd0);
        check_vec("rst_adr", {27'd0, rf_w_adr}, 32'd0);
        check_vec("rst_data", rf_w_data, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single mem write
        mem_valid = 1; mem_adr = 5'd3; mem_data = 32'h1234_5678;
        #1;
        check_vec("single_mem_ready", {31'd0, mem_ready}, 32'd1);
        check_vec("single_alu_ready", {31'd0, alu_ready}, 32'd0);
        tick();
        mem_valid = 0;
        check_vec("single_en", {31'd0, rf_en}, 32'd1);
        check_vec("single_adr", {27'd0, rf_w_adr}, 32'd3);
        check_vec("single_data", rf_w_data, 32'h1234_5678);
        tick();
        check_vec("single_en_drop", {31'd0, rf_en}, 32'd0);
        check_vec("single_adr_hold", {27'd0, rf_w_adr}, 32'd3);

        // Scoreboard set by issue, cleared by write
        issue_valid = 1; issue_adr = 5'd7; chk_adr1 = 5'd7; chk_adr2 = 5'd7;
        #1;
        check_vec("sb_hz1_before", {31'd0, hz1}, 32'd0);
        tick();
        issue_valid = 0;
        #1;
        check_vec("sb_hz1_set", {31'd0, hz1}, 32'd1);
        check_vec("sb_hz2_set", {31'd0, hz2}, 32'd1);
        check_vec("sb_hzrd_set", {31'd0, hz_rd}, 32'd1);
        mem_valid = 1; mem_adr = 5'd7; mem_data = 32'hAAAA_5555;
        tick();
        mem_valid = 0;
        #1;
        check_vec("sb_hz1_clr", {31'd0, hz1}, 32'd0);
        check_vec("sb_hzrd_clr", {31'd0, hz_rd}, 32'd0);
        check_vec("sb_wr_adr", {27'd0, rf_w_adr}, 32'd7);

        // x0 write with register 11 pending
        issue_valid = 1; issue_adr = 5'd11; chk_adr1 = 5'd11;
        tick();
        issue_valid = 0; issue_adr = 5'd0;
        alu_valid = 1; alu_adr = 5'd0; alu_data = 32'hFFFF_FFFF;
        #1;
        check_vec("x0_alu_ready", {31'd0, alu_ready}, 32'd1);
        tick();
        alu_valid = 0;
        #1;
        check_vec("x0_rf_en", {31'd0, rf_en}, 32'd0);
        check_vec("x0_data", rf_w_data, 32'hFFFF_FFFF);
        check_vec("x0_pending11", {31'd0, hz1}, 32'd1);

        // Continuous contention: starvation counter forces an ALU slot every fifth cycle
        mem_valid = 1; mem_adr = 5'd1; mem_data = 32'h0000_0100;
        alu_valid = 1; alu_adr = 5'd2; alu_data = 32'h0000_0200;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_vec($sformatf("cont_mem_ready%0d", i), {31'd0, mem_ready}, {31'd0, exp_mem[i]});
            check_vec($sformatf("cont_alu_ready%0d", i), {31'd0, alu_ready}, {31'd0, ~exp_mem[i]});
            tick();
            check_vec($sformatf("cont_adr%0d", i), {27'd0, rf_w_adr}, exp_mem[i] ? 32'd1 : 32'd2);
        end
        mem_valid = 0; alu_valid = 0;
        tick();

        // Same-edge set and clear on register 9: set wins
        issue_valid = 1; issue_adr = 5'd9; chk_adr1 = 5'd9;
        alu_valid = 1; alu_adr = 5'd9; alu_data = 32'h0000_0099;
        #1;
        check_vec("same_alu_ready", {31'd0, alu_ready}, 32'd1);
        tick();
        issue_valid = 0; alu_valid = 0;
        #1;
        check_vec("same_pending9", {31'd0, hz1}, 32'd1);
        check_vec("same_rf_en", {31'd0, rf_en}, 32'd1);
        check_vec("same_data", rf_w_data, 32'h0000_0099);
        mem_valid = 1; mem_adr = 5'd9; mem_data = 32'h0000_0909;
        tick();
        mem_valid = 0;
        #1;
        check_vec("same_clr9", {31'd0, hz1}, 32'd0);

        // Reset mid-write drops the registered write and the pending mask
        chk_adr2 = 5'd11;
        #1;
        check_vec("pre_rst_pending11", {31'd0, hz2}, 32'd1);
        mem_valid = 1; mem_adr = 5'd5; mem_data = 32'hDEAD_BEEF;
        tick();
        mem_valid = 0;
        check_vec("mid_en", {31'd0, rf_en}, 32'd1);
        check_vec("mid_data", rf_w_data, 32'hDEAD_BEEF);
        rst_n = 1'b0;
        #1;
        check_vec("rst_mid_en", {31'd0, rf_en}, 32'd0);
        check_vec("rst_mid_adr", {27'd0, rf_w_adr}, 32'd0);
        check_vec("rst_mid_data", rf_w_data, 32'd0);
        check_vec("rst_mid_hz2", {31'd0, hz2}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
